// File: rtl/acc_store_unit.sv
// acc_store_unit: buffers accumulator store requests in an in-order queue
// and drains each entry to data memory over a req/ack write handshake.
// Reports queue occupancy, busy, and sticky overflow/timeout error flags.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no write in flight; launches the head entry when count > 0
// S_REQ  | mem_wr_req high, addr/data held; waits for ack or timeout
module acc_store_unit #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         st_valid,
    output logic                         st_ready,
    input  logic [ADDR_W-1:0]            st_addr,
    input  logic [DATA_W-1:0]            acc_in,
    output logic                         mem_wr_req,
    output logic [ADDR_W-1:0]            mem_wr_addr,
    output logic [DATA_W-1:0]            mem_wr_data,
    input  logic                         mem_wr_ack,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         err_overflow,
    output logic                         err_timeout,
    input  logic                         err_clear
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] FULL_C   = CNT_W'(DEPTH);
    // Down-counter load value: terminal count 0 is reached after TIMEOUT
    // cycles of mem_wr_req high.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit               TO_EN    = (TIMEOUT != 0);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ADDR_W-1:0]  q_addr [DEPTH];
    logic [DATA_W-1:0]  q_data [DEPTH];
    logic [TMR_W-1:0]   tmr;
    logic               push;
    logic               pop;
    logic               load;
    logic               to_hit;

    // st_ready comes from the registered count only, so a pop cannot
    // reopen a full queue within the same cycle.
    assign st_ready   = (count < FULL_C);
    assign push       = st_valid && st_ready;
    assign mem_wr_req = (state == S_REQ);
    assign busy       = (count != '0) || mem_wr_req;

    // State register; reset drops mem_wr_req without waiting for a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decisions; ack takes priority over timeout.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        pop       = 1'b0;
        to_hit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    load      = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_wr_ack) begin
                    pop       = 1'b1;
                    state_nxt = S_IDLE;
                end else if (TO_EN && (tmr == '0)) begin
                    pop       = 1'b1;
                    to_hit    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Write timeout down-counter, reloaded each time a write is launched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr <= '0;
        end else if (load) begin
            tmr <= TMR_LOAD;
        end else if ((state == S_REQ) && (tmr != '0)) begin
            tmr <= tmr - 1'b1;
        end
    end

    // Capture the head entry onto the memory bus when a write is launched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else if (load) begin
            mem_wr_addr <= q_addr[rd_ptr];
            mem_wr_data <= q_data[rd_ptr];
        end
    end

    // Queue storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= st_addr;
            q_data[wr_ptr] <= acc_in;
        end
    end

    // Circular-buffer pointers and occupancy count (includes in-flight entry).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a set event beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            err_overflow <= (st_valid && !st_ready) || (err_overflow && !err_clear);
            err_timeout  <= to_hit || (err_timeout && !err_clear);
        end
    end

endmodule

// File: tb/tb_acc_store_unit.sv
// Self-checking bench for acc_store_unit: directed scenarios followed by a
// random phase, all checked every cycle against a queue-based reference model.
module tb_acc_store_unit;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              st_valid = 1'b0;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr = '0;
    logic [DATA_W-1:0] acc_in = '0;
    logic              mem_wr_req;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_ack = 1'b0;
    logic              busy;
    logic [CNT_W-1:0]  count;
    logic              err_overflow;
    logic              err_timeout;
    logic              err_clear = 1'b0;

    acc_store_unit #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_addr      (st_addr),
        .acc_in       (acc_in),
        .mem_wr_req   (mem_wr_req),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_ack   (mem_wr_ack),
        .busy         (busy),
        .count        (count),
        .err_overflow (err_overflow),
        .err_timeout  (err_timeout),
        .err_clear    (err_clear)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;

    // Reference model: pending entries in FIFO order, the write in flight
    // and how many cycles its request has been high so far.
    ent_t m_q[$];
    ent_t got[$];
    bit   req_log[$];
    bit   m_active;
    int   m_cyc;
    ent_t m_cur;
    bit   m_ovf;
    bit   m_to;

    int   idx, r1, gap, r2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_active = 1'b0;
        m_cyc    = 0;
        m_cur    = '0;
        m_ovf    = 1'b0;
        m_to     = 1'b0;
    endtask

    task automatic drv(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic ack, input logic clr);
        st_valid   = v;
        st_addr    = a;
        acc_in     = d;
        mem_wr_ack = ack;
        err_clear  = clr;
    endtask

    task automatic check_all();
        chk("st_ready", 32'(st_ready), 32'(m_q.size() < DEPTH));
        chk("count", 32'(count), 32'(m_q.size()));
        chk("mem_wr_req", 32'(mem_wr_req), 32'(m_active));
        chk("busy", 32'(busy), 32'((m_q.size() != 0) || m_active));
        chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
        chk("err_timeout", 32'(err_timeout), 32'(m_to));
        if (m_active) begin
            chk("mem_wr_addr", 32'(mem_wr_addr), 32'(m_cur.a));
            chk("mem_wr_data", 32'(mem_wr_data), 32'(m_cur.d));
        end
    endtask

    // One clock: sample inputs, advance the model at the edge, check at +1.
    task automatic step();
        logic v, ack, clr, req_pre, room, ovf_set, to_set;
        ent_t in_e, w_pre;
        v       = st_valid;
        ack     = mem_wr_ack;
        clr     = err_clear;
        in_e.a  = st_addr;
        in_e.d  = acc_in;
        req_pre = mem_wr_req;
        w_pre.a = mem_wr_addr;
        w_pre.d = mem_wr_data;
        @(posedge clk);
        if (req_pre === 1'b1 && ack) got.push_back(w_pre);
        if (!reset_n) begin
            model_reset();
        end else begin
            room    = (m_q.size() < DEPTH);
            ovf_set = v && !room;
            to_set  = 1'b0;
            if (m_active) begin
                if (ack) begin
                    void'(m_q.pop_front());
                    m_active = 1'b0;
                end else if (TIMEOUT != 0 && m_cyc == TIMEOUT) begin
                    void'(m_q.pop_front());
                    m_active = 1'b0;
                    to_set   = 1'b1;
                end else begin
                    m_cyc++;
                end
            end else if (m_q.size() != 0) begin
                m_active = 1'b1;
                m_cyc    = 1;
                m_cur    = m_q[0];
            end
            if (v && room) m_q.push_back(in_e);
            m_ovf = ovf_set || (m_ovf && !clr);
            m_to  = to_set || (m_to && !clr);
        end
        #1;
        check_all();
        req_log.push_back(mem_wr_req);
    endtask

    function automatic int ones();
        int n = 0;
        foreach (req_log[i]) n += int'(req_log[i]);
        return n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for 3 cycles with random inputs.
        model_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            step();
            chk("rst_wr_addr", 32'(mem_wr_addr), 32'(0));
            chk("rst_wr_data", 32'(mem_wr_data), 32'(0));
        end
        drv(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        reset_n = 1'b1;
        step();

        // Single store, ack arriving two cycles after the request rises.
        got.delete();
        req_log.delete();
        drv(1'b1, 8'h10, 8'hA5, 1'b0, 1'b0);
        step();
        drv(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        step();
        step();
        step();
        drv(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        step();
        drv(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        step();
        chk("single_req_cycles", 32'(ones()), 32'(3));
        chk("single_writes", 32'(got.size()), 32'(1));
        if (got.size() > 0) chk("single_write", 32'(got[0]), 32'h10A5);
        chk("single_idle_count", 32'(count), 32'(0));
        chk("single_idle_busy", 32'(busy), 32'(0));

        // Fill with ack held low, then one overflowing push.
        got.delete();
        for (int i = 1; i <= 4; i++) begin
            drv(1'b1, 8'(i), 8'(i * 17), 1'b0, 1'b0);
            step();
        end
        chk("full_ready", 32'(st_ready), 32'(0));
        drv(1'b1, 8'h05, 8'h55, 1'b0, 1'b0);
        step();
        chk("full_overflow", 32'(err_overflow), 32'(1));
        chk("full_count", 32'(count), 32'(4));
        drv(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 40 && (m_q.size() != 0 || m_active); i++) step();
        step();
        chk("drain_writes", 32'(got.size()), 32'(4));
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            chk("drain_order", 32'(got[i]), 32'({8'(i + 1), 8'((i + 1) * 17)}));
        end
        chk("drain_count", 32'(count), 32'(0));
        drv(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        step();
        chk("clear_overflow", 32'(err_overflow), 32'(0));

        // Timeout: two entries, never acknowledged.
        got.delete();
        req_log.delete();
        drv(1'b1, 8'h21, 8'h31, 1'b0, 1'b0);
        step();
        drv(1'b1, 8'h22, 8'h32, 1'b0, 1'b0);
        step();
        drv(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (22) step();
        idx = 0; r1 = 0; gap = 0; r2 = 0;
        while (idx < req_log.size() && !req_log[idx]) idx++;
        while (idx < req_log.size() && req_log[idx]) begin r1++; idx++; end
        while (idx < req_log.size() && !req_log[idx]) begin gap++; idx++; end
        while (idx < req_log.size() && req_log[idx]) begin r2++; idx++; end
        chk("timeout_req1_len", 32'(r1), 32'(TIMEOUT));
        chk("timeout_gap", 32'(gap), 32'(1));
        chk("timeout_req2_len", 32'(r2), 32'(TIMEOUT));
        chk("timeout_flag", 32'(err_timeout), 32'(1));
        chk("timeout_no_writes", 32'(got.size()), 32'(0));
        drv(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        step();
        chk("clear_timeout", 32'(err_timeout), 32'(0));

        // Ack landing on the same edge the timeout would fire.
        got.delete();
        drv(1'b1, 8'h30, 8'h40, 1'b0, 1'b0);
        step();
        drv(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        step();
        chk("edge_req_up", 32'(mem_wr_req), 32'(1));
        repeat (TIMEOUT - 1) step();
        drv(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        step();
        drv(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        step();
        chk("edge_no_timeout", 32'(err_timeout), 32'(0));
        chk("edge_writes", 32'(got.size()), 32'(1));
        if (got.size() > 0) chk("edge_write", 32'(got[0]), 32'h3040);

        // Overflow arriving together with err_clear keeps the flag set.
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, 8'(8'h50 + i), 8'(8'h60 + i), 1'b0, 1'b0);
            step();
        end
        chk("ovf_set", 32'(err_overflow), 32'(1));
        drv(1'b1, 8'h5F, 8'h6F, 1'b0, 1'b1);
        step();
        chk("ovf_clear_vs_set", 32'(err_overflow), 32'(1));
        drv(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        step();
        chk("ovf_cleared", 32'(err_overflow), 32'(0));
        drv(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 40 && (m_q.size() != 0 || m_active); i++) step();
        drv(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        step();

        // Reset asserted mid-write with three entries queued.
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 8'(8'h70 + i), 8'(8'h80 + i), 1'b0, 1'b0);
            step();
        end
        drv(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("midrst_req_before", 32'(mem_wr_req), 32'(1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_req_async", 32'(mem_wr_req), 32'(0));
        chk("midrst_count_async", 32'(count), 32'(0));
        model_reset();
        step();
        reset_n = 1'b1;
        got.delete();
        req_log.delete();
        drv(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        repeat (10) step();
        chk("midrst_no_reissue", 32'(ones()), 32'(0));
        chk("midrst_no_writes", 32'(got.size()), 32'(0));

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drv(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 19) == 0));
            step();
        end
        drv(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 40 && (m_q.size() != 0 || m_active); i++) step();
        step();
        chk("final_count", 32'(count), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_store_unit.md
Name: acc_store_unit

Overview:
- Consumer side of the accumulator. Accepts store requests from the control unit: the current accumulator value plus a target address.
- Buffers requests in a small in-order queue.
- Drains each entry to data memory over a req/ack write handshake.
- Reports busy, queue occupancy, overflow errors and write-timeout errors to the control unit.

Parameters:
- DATA_W, 8, width of the accumulator value and memory write data.
- ADDR_W, 8, width of the memory address.
- DEPTH, 4, queue entries; power of two, ≥2.
- TIMEOUT, 16, maximum cycles mem_wr_req waits for ack; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- st_valid  in  1  store request from the control unit.
- st_ready  out  1  queue can accept an entry.
- st_addr  in  ADDR_W  store address.
- acc_in  in  DATA_W  accumulator value to store.
- mem_wr_req  out  1  memory write request.
- mem_wr_addr  out  ADDR_W  write address, stable while req is high.
- mem_wr_data  out  DATA_W  write data, stable while req is high.
- mem_wr_ack  in  1  memory write accepted.
- busy  out  1  queue non-empty or write in flight.
- count  out  $clog2(DEPTH+1)  entries currently queued, including the in-flight entry.
- err_overflow  out  1  sticky: st_valid seen while st_ready was low.
- err_timeout  out  1  sticky: a write was dropped on timeout.
- err_clear  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (reset_n low, asynchronous):
  - queue empty, count=0, FSM=IDLE.
  - mem_wr_req=0, mem_wr_addr=0, mem_wr_data=0.
  - busy=0, err_overflow=0, err_timeout=0.
  - st_ready=1.
  - Reset asserted mid-write drops mem_wr_req immediately and discards all queued entries.
- Enqueue:
  - Entry {st_addr, acc_in} is written at the rising edge where st_valid && st_ready.
  - st_ready = (count < DEPTH), derived from registered count only. There is no bypass: when full, a pop in the same cycle does not raise st_ready.
  - st_valid && !st_ready: request discarded, err_overflow set at that edge.
- Queue: circular buffer with read/write pointers that wrap modulo DEPTH. Entries are written to memory strictly in FIFO order.
- FSM states:
  - IDLE:
    - if count>0, the head entry is loaded into mem_wr_addr/mem_wr_data and mem_wr_req is driven to 1 at the same edge; go to REQ. The timeout counter is cleared.
    - An entry accepted at edge k produces mem_wr_req=1 after edge k+1.
  - REQ:
    - mem_wr_req held at 1; addr/data held stable.
    - mem_wr_ack=1 at an edge: pop the head, count decrements, mem_wr_req=0, go to IDLE.
    - Otherwise the timeout counter increments. When TIMEOUT≠0 and the counter reaches TIMEOUT-1 with no ack: pop the head, set err_timeout, mem_wr_req=0, go to IDLE. mem_wr_req is therefore high for exactly TIMEOUT cycles.
    - Ack and timeout on the same edge: ack wins, no error.
- Throughput: at least one IDLE cycle between writes, so the maximum rate is one write per 2 cycles.
- mem_wr_ack while in IDLE is ignored.
- Simultaneous push and pop: count unchanged, both pointers advance.
- count and busy:
  - count is registered.
  - busy = (count≠0) || mem_wr_req.
- Sticky flags:
  - err_clear clears both flags at the edge.
  - A set event in the same cycle as err_clear wins: the flag reads 1.
- Combinational paths: mem_wr_ack has no combinational path to any output.

Test Plan:
- Reset: hold reset_n low for 3 cycles with random inputs → mem_wr_req=0, count=0, busy=0, both error flags 0, st_ready=1.
- Single store: st_addr=0x10, acc_in=0xA5 for 1 cycle; ack 2 cycles after req rises → one write of 0x10/0xA5; req high for 3 cycles; then count=0, busy=0.
- Fill and overflow:
  - Hold mem_wr_ack low; push (0x01,0x11)…(0x04,0x44), then a 5th push (0x05,0x55) → st_ready=0 after the 4th; err_overflow=1; count=4.
  - Then ack every request → writes appear in order 0x01..0x04 only; count returns to 0.
- Timeout: TIMEOUT=8, two entries queued, never ack → first req high exactly 8 cycles; err_timeout=1; second entry (and its req) issued after one IDLE cycle.
- Ack on the timeout edge (ack in the 8th REQ cycle, TIMEOUT=8) → entry popped, err_timeout stays 0. err_clear pulsed together with a new overflow → err_overflow stays 1.
- Reset mid-write: assert reset_n low while in REQ with 3 entries queued → mem_wr_req falls without waiting for clk; after release, count=0 and no write is reissued.
